// File: rtl/stack_pkg.sv
// Shared encodings for the stack controller: op codes, FSM states and default bounds.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_LOAD = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BURST_PUSH = 2'd1,
        ST_BURST_POP  = 2'd2
    } state_e;

    localparam logic [7:0] DEF_STACK_TOP   = 8'hFF;
    localparam logic [7:0] DEF_STACK_LIMIT = 8'hAF;

endpackage

// File: rtl/stack_bounds.sv
// Combinational space/occupancy checks for a descending, empty-descending stack.
module stack_bounds
    import stack_pkg::*;
#(
    parameter int            AW          = 8,
    parameter logic [AW-1:0] STACK_TOP   = DEF_STACK_TOP,
    parameter logic [AW-1:0] STACK_LIMIT = DEF_STACK_LIMIT,
    parameter int            CALL_BEATS  = 2
) (
    input  logic [AW-1:0] i_sp,
    input  logic [AW-1:0] i_load_val,
    output logic          o_push_ok1,
    output logic          o_push_okn,
    output logic          o_pop_ok1,
    output logic          o_pop_okn,
    output logic          o_load_ok
);

    localparam logic [AW-1:0] NB   = AW'(CALL_BEATS);
    localparam logic [AW-1:0] SPAN = STACK_TOP - STACK_LIMIT;

    logic [AW-1:0] w_free;
    logic [AW-1:0] w_used;
    logic [AW-1:0] w_ld_off;

    assign w_free = i_sp - STACK_LIMIT;
    assign w_used = STACK_TOP - i_sp;
    // Values below the limit wrap to large offsets, so one compare covers both ends.
    assign w_ld_off = i_load_val - STACK_LIMIT;

    assign o_push_ok1 = (w_free != '0);
    assign o_push_okn = (w_free >= NB);
    assign o_pop_ok1  = (w_used != '0);
    assign o_pop_okn  = (w_used >= NB);
    assign o_load_ok  = (w_ld_off <= SPAN);

endmodule

// File: rtl/stack_ctrl.sv
// Stack pointer owner: single-word PUSH/POP/LOAD and multi-beat CALL/RET with sticky errors.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int            AW          = 8,
    parameter logic [AW-1:0] STACK_TOP   = DEF_STACK_TOP,
    parameter logic [AW-1:0] STACK_LIMIT = DEF_STACK_LIMIT,
    parameter int            CALL_BEATS  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    op,
    output logic          op_ready,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] sp,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [1:0]    beat,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic          ldrr,
    input  logic          clr_err
);

    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [1:0]    LAST    = 2'(CALL_BEATS - 1);
    localparam logic          MULTI   = (CALL_BEATS > 1);

    state_e        r_state;
    logic [1:0]    r_beat;
    logic [AW-1:0] r_sp;
    logic          r_ovf;
    logic          r_unf;
    logic          r_ldrr;

    logic w_push_ok1, w_push_okn, w_pop_ok1, w_pop_okn, w_load_ok;
    logic w_set_ovf, w_set_unf, w_set_ldrr, w_ld;
    logic w_start_push, w_start_pop;

    stack_bounds #(
        .AW          (AW),
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT),
        .CALL_BEATS  (CALL_BEATS)
    ) u_bounds (
        .i_sp       (r_sp),
        .i_load_val (load_val),
        .o_push_ok1 (w_push_ok1),
        .o_push_okn (w_push_okn),
        .o_pop_ok1  (w_pop_ok1),
        .o_pop_okn  (w_pop_okn),
        .o_load_ok  (w_load_ok)
    );

    assign op_ready = (r_state == ST_IDLE);
    assign sp       = r_sp;
    assign full     = (r_sp == STACK_LIMIT);
    assign empty    = (r_sp == STACK_TOP);
    assign ovf      = r_ovf;
    assign unf      = r_unf;
    assign ldrr     = r_ldrr;

    // Strobes come straight from the accepted op or the live burst beat.
    always_comb begin
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = r_sp;
        beat         = 2'd0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        w_set_ldrr   = 1'b0;
        w_ld         = 1'b0;
        w_start_push = 1'b0;
        w_start_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_PUSH: begin
                            mem_we    = w_push_ok1;
                            w_set_ovf = !w_push_ok1;
                        end
                        OP_POP: begin
                            mem_re    = w_pop_ok1;
                            mem_addr  = r_sp + ONE;
                            w_set_unf = !w_pop_ok1;
                        end
                        OP_LOAD: begin
                            w_ld       = w_load_ok;
                            w_set_ldrr = !w_load_ok;
                        end
                        OP_CALL: begin
                            mem_we       = w_push_okn;
                            w_set_ovf    = !w_push_okn;
                            w_start_push = w_push_okn && MULTI;
                        end
                        OP_RET: begin
                            mem_re      = w_pop_okn;
                            mem_addr    = r_sp + ONE;
                            w_set_unf   = !w_pop_okn;
                            w_start_pop = w_pop_okn && MULTI;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BURST_PUSH: begin
                mem_we = 1'b1;
                beat   = r_beat;
            end
            ST_BURST_POP: begin
                mem_re   = 1'b1;
                mem_addr = r_sp + ONE;
                beat     = r_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= 2'd0;
            r_sp    <= STACK_TOP;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_ldrr  <= 1'b0;
        end else begin
            if (mem_we)
                r_sp <= r_sp - ONE;
            else if (mem_re)
                r_sp <= r_sp + ONE;
            else if (w_ld)
                r_sp <= load_val;

            // A new error in the same cycle as clr_err wins.
            r_ovf  <= w_set_ovf  | (r_ovf  & ~clr_err);
            r_unf  <= w_set_unf  | (r_unf  & ~clr_err);
            r_ldrr <= w_set_ldrr | (r_ldrr & ~clr_err);

            case (r_state)
                ST_IDLE: begin
                    if (w_start_push) begin
                        r_state <= ST_BURST_PUSH;
                        r_beat  <= 2'd1;
                    end else if (w_start_pop) begin
                        r_state <= ST_BURST_POP;
                        r_beat  <= 2'd1;
                    end
                end
                ST_BURST_PUSH, ST_BURST_POP: begin
                    if (r_beat == LAST) begin
                        r_state <= ST_IDLE;
                        r_beat  <= 2'd0;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random ops against a queue-based stack model.
module tb_stack_ctrl;

    localparam int TOP = 255;
    localparam int LIM = 175;
    localparam int NB  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [2:0] op;
    logic       op_ready;
    logic [7:0] load_val;
    logic [7:0] sp;
    logic [7:0] mem_addr;
    logic       mem_we, mem_re;
    logic [1:0] beat;
    logic       full, empty, ovf, unf, ldrr;
    logic       clr_err;

    stack_ctrl #(
        .AW(8), .STACK_TOP(8'hFF), .STACK_LIMIT(8'hAF), .CALL_BEATS(NB)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .load_val(load_val), .sp(sp), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_re(mem_re), .beat(beat), .full(full), .empty(empty), .ovf(ovf),
        .unf(unf), .ldrr(ldrr), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      we;
        int      addr;
        int      bt;
    } beat_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_sp;
    bit    m_ovf, m_unf, m_ldrr;
    beat_t pend[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_sp = TOP; m_ovf = 0; m_unf = 0; m_ldrr = 0;
    endtask

    // One cycle: drive at negedge, predict and compare, then advance the model at posedge.
    task automatic cyc(input bit v, input int o, input int lv, input bit c);
        bit e_ready, e_we, e_re, s_ovf, s_unf, s_ldrr, ld;
        int e_addr, e_beat;
        beat_t b;
        @(negedge clk);
        op_valid = v; op = 3'(o); load_val = 8'(lv); clr_err = c;
        #1;
        e_ready = (pend.size() == 0);
        e_we = 0; e_re = 0; e_addr = 0; e_beat = 0;
        s_ovf = 0; s_unf = 0; s_ldrr = 0; ld = 0;
        if (!e_ready) begin
            b = pend.pop_front();
            e_we = b.we; e_re = !b.we; e_addr = b.addr; e_beat = b.bt;
        end else if (v) begin
            case (o)
                1: if (m_sp - LIM >= 1) begin e_we = 1; e_addr = m_sp; end else s_ovf = 1;
                2: if (TOP - m_sp >= 1) begin e_re = 1; e_addr = m_sp + 1; end else s_unf = 1;
                3: if (lv >= LIM && lv <= TOP) ld = 1; else s_ldrr = 1;
                4: if (m_sp - LIM >= NB) begin
                       e_we = 1; e_addr = m_sp;
                       for (int k = 1; k < NB; k++) pend.push_back('{1'b1, m_sp - k, k});
                   end else s_ovf = 1;
                5: if (TOP - m_sp >= NB) begin
                       e_re = 1; e_addr = m_sp + 1;
                       for (int k = 1; k < NB; k++) pend.push_back('{1'b0, m_sp + 1 + k, k});
                   end else s_unf = 1;
                default: ;
            endcase
        end
        chk("sp", int'(sp), m_sp);
        chk("op_ready", int'(op_ready), int'(e_ready));
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_re", int'(mem_re), int'(e_re));
        chk("beat", int'(beat), e_beat);
        chk("full", int'(full), int'(m_sp == LIM));
        chk("empty", int'(empty), int'(m_sp == TOP));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("unf", int'(unf), int'(m_unf));
        chk("ldrr", int'(ldrr), int'(m_ldrr));
        if (e_we || e_re) chk("mem_addr", int'(mem_addr), e_addr);
        @(posedge clk);
        if (ld) m_sp = lv;
        else m_sp = m_sp - int'(e_we) + int'(e_re);
        m_ovf  = s_ovf  | (m_ovf  & !c);
        m_unf  = s_unf  | (m_unf  & !c);
        m_ldrr = s_ldrr | (m_ldrr & !c);
        #1;
    endtask

    initial begin
        int o, lv;
        rst = 1'b1; op_valid = 0; op = 0; load_val = 0; clr_err = 0;
        #1;
        model_reset();
        chk("rst_sp", int'(sp), 'hFF);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_ready", int'(op_ready), 1);
        chk("rst_empty", int'(empty), 1);
        #12 rst = 1'b0;

        repeat (3) cyc(1, 1, 0, 0);
        chk("pin_sp_fc", int'(sp), 'hFC);
        chk("pin_not_empty", int'(empty), 0);
        repeat (3) cyc(1, 2, 0, 0);
        chk("pin_sp_ff", int'(sp), 'hFF);
        cyc(1, 2, 0, 0);
        chk("pin_unf", int'(unf), 1);
        cyc(0, 0, 0, 1);
        chk("pin_unf_clr", int'(unf), 0);

        cyc(1, 3, 'hB0, 0);
        cyc(1, 1, 0, 0);
        chk("pin_sp_af", int'(sp), 'hAF);
        chk("pin_full", int'(full), 1);
        cyc(1, 1, 0, 0);
        chk("pin_ovf", int'(ovf), 1);
        cyc(1, 3, 'h10, 0);
        chk("pin_ld_sp", int'(sp), 'hAF);
        chk("pin_ldrr", int'(ldrr), 1);
        cyc(0, 0, 0, 1);

        cyc(1, 3, 'hB0, 0);
        cyc(1, 4, 0, 0);
        chk("pin_call_ref_sp", int'(sp), 'hB0);
        chk("pin_call_ref_ovf", int'(ovf), 1);
        cyc(1, 3, 'hFF, 1);
        cyc(1, 4, 0, 0);
        cyc(1, 1, 0, 0);
        chk("pin_call_sp", int'(sp), 'hFD);
        cyc(1, 5, 0, 0);
        cyc(1, 2, 0, 0);
        chk("pin_ret_sp", int'(sp), 'hFF);
        chk("pin_ret_empty", int'(empty), 1);

        // Reset while beat 1 of a CALL is on the bus.
        cyc(1, 4, 0, 0);
        @(negedge clk);
        op_valid = 0; rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_sp", int'(sp), 'hFF);
        chk("midrst_we", int'(mem_we), 0);
        chk("midrst_ready", int'(op_ready), 1);
        #2 rst = 1'b0;
        cyc(0, 0, 0, 0);

        cyc(1, 3, 'hAF, 0);
        cyc(1, 1, 0, 1);
        chk("pin_set_wins", int'(ovf), 1);

        for (int i = 0; i < 3000; i++) begin
            o  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                 : (($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(1, 5)));
            lv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(LIM, TOP))
                 : int'($urandom_range(0, 255));
            cyc($urandom_range(0, 4) != 0, o, lv, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: sim did not finish, expected end by 2000000");
        $fatal(1);
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Parametrised hardware stack controller, successor to the fixed 8-bit stack pointer. It owns the stack pointer (SP) and drives the data-memory address and strobes for single-word PUSH and POP, SP load, and multi-beat CALL/RET bursts that save or restore the PC. It adds full/empty status, sticky overflow/underflow/bad-load error flags, and atomic burst bounds checking. It sits between the control unit and data memory.

Parameters:
AW, 8, address and SP width in bits
STACK_TOP, 8'hFF, SP reset value; empty when SP == STACK_TOP
STACK_LIMIT, 8'hAF, lowest legal SP; full when SP == STACK_LIMIT (capacity = TOP-LIMIT = 80 words)
CALL_BEATS, 2, words pushed by CALL and popped by RET (1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op_valid  in  1  operation request
op  in  3  0 NOP, 1 PUSH, 2 POP, 3 LOAD, 4 CALL, 5 RET; 6 and 7 are treated as NOP
op_ready  out  1  high when the controller can accept an op (state IDLE)
load_val  in  AW  new SP for LOAD
sp  out  AW  current stack pointer
mem_addr  out  AW  data-memory address for the current beat
mem_we  out  1  write strobe, one cycle per pushed word
mem_re  out  1  read strobe, one cycle per popped word
beat  out  2  beat index within a CALL/RET (0 for single ops)
full  out  1  SP == STACK_LIMIT
empty  out  1  SP == STACK_TOP
ovf  out  1  sticky: push or call refused for lack of space
unf  out  1  sticky: pop or ret refused for lack of data
ldrr  out  1  sticky: LOAD value outside [STACK_LIMIT, STACK_TOP]
clr_err  in  1  synchronous clear of ovf, unf and ldrr

Behaviour:
- Reset (async, any state): SP=STACK_TOP, state IDLE, mem_we=mem_re=0, beat=0, ovf=unf=ldrr=0. Reset mid-burst abandons the burst; no further strobes are issued.
- Stack is descending, empty-descending: SP points to the next free slot. free = SP-STACK_LIMIT; used = STACK_TOP-SP.
- Accept = op_valid & op_ready. Strobes are combinational from the accepted op or the current burst beat. SP updates on the same clock edge.
- PUSH: if free>=1, mem_addr=SP, mem_we=1, SP<=SP-1. Otherwise no strobe, SP unchanged, ovf<=1.
- POP: if used>=1, mem_addr=SP+1, mem_re=1, SP<=SP+1. Otherwise no strobe, unf<=1.
- LOAD: if STACK_LIMIT<=load_val<=STACK_TOP, SP<=load_val. Otherwise SP unchanged, ldrr<=1. No strobes.
- CALL: bounds-checked atomically at accept; requires free>=CALL_BEATS.
  - If it fails: ovf<=1, no strobes, stays IDLE.
  - If it passes: beat 0 is issued in the accept cycle as a PUSH, then the FSM moves to BURST_PUSH, which issues beats 1..CALL_BEATS-1 one per cycle.
  - op_ready=0 for the remaining beats. After the last beat the FSM returns to IDLE.
- RET: same scheme with POP semantics, requires used>=CALL_BEATS, otherwise unf<=1. The FSM uses BURST_POP.
- CALL_BEATS=1 degenerates to a single-cycle op with no BURST state.
- FSM states: IDLE, BURST_PUSH, BURST_POP. A beat counter counts to CALL_BEATS-1.
- Latency: single ops take 1 cycle. CALL/RET take CALL_BEATS cycles. The next op is accepted in the cycle after the last beat.
- Error flags: clr_err clears them. If clr_err and a new error occur in the same cycle, set wins. The flags do not block operation.
- full/empty are combinational from SP. SP never leaves [STACK_LIMIT, STACK_TOP]; there is no wrap-around.

Decomposition:
- Shared package (stack_pkg): op encodings (OP_NOP..OP_RET), FSM state enum, default TOP/LIMIT constants.
- One sub-module is natural: stack_bounds. It is combinational and computes free, used, push_ok(n), pop_ok(n) and load_ok from SP, load_val and the parameters.

Test Plan:
- Reset, then 3 PUSH -> mem_addr FF, FE, FD with mem_we each cycle; sp=FC; empty=0.
- From SP=FC, POP -> mem_re=1, mem_addr=FD, sp=FD. POP until sp=FF, then one more POP -> no mem_re, sp stays FF, unf=1; clr_err -> unf=0.
- LOAD B0, then PUSH -> mem_addr=B0, sp=AF, full=1. Next PUSH -> refused, ovf=1. LOAD 10 -> sp stays AF, ldrr=1.
- At sp=B0 (free=1), CALL with CALL_BEATS=2 -> refused atomically: no mem_we, sp=B0, ovf=1. At sp=FF, CALL -> mem_we at FF (beat 0), then FE (beat 1); op_ready=0 in the second cycle; sp=FD.
- At sp=FD, RET -> mem_re at FE (beat 0), then FF (beat 1); sp=FF, empty=1.
- Assert rst during beat 1 of a CALL -> sp=FF immediately, no further mem_we, op_ready=1 after release. Also: clr_err in the same cycle as a refused PUSH -> ovf=1.
